// File: rtl/sim_monitor_pkg.sv
// Shared types for the simulation end-of-test monitor.
// Holds the monitor state and verdict code encodings.
package sim_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } mon_state_e;

   typedef enum logic [2:0] {
      FAIL_NONE     = 3'd0,
      FAIL_PC_X     = 3'd1,
      FAIL_SIG_FAIL = 3'd2,
      FAIL_TIMEOUT  = 3'd3,
      FAIL_X0_WRITE = 3'd4
   } fail_code_e;

endpackage

// File: rtl/sim_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module sat_counter
   import sim_monitor_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != '1))
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk)
      cnt_q <= cnt_d;

   assign q = cnt_q;

endmodule

// File: rtl/sim_monitor.sv
// End-of-test monitor: watches PC, regfile writes and retires, emits a verdict.
// Define SIM_MONITOR_X0_STRICT_EN to make nonzero x0 writes a fatal verdict.
module sim_monitor
   import sim_monitor_pkg::*;
#(
   parameter int unsigned     XLEN           = 64,
   parameter int unsigned     TIMEOUT_CYCLES = 1000,
   parameter int unsigned     DRAIN_CYCLES   = 10,
   parameter int unsigned     SIG_REG        = 31,
   parameter logic [XLEN-1:0] PASS_SIG       = 'h7FF,
   parameter logic [XLEN-1:0] FAIL_SIG       = 'hBAD,
   parameter int unsigned     CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  pc_f,
   input  logic             rf_we,
   input  logic [4:0]       rf_a3,
   input  logic [XLEN-1:0]  rf_wd3,
   input  logic             retire,
   output logic             done,
   output logic             pass,
   output logic [2:0]       fail_code,
   output logic             dump_req,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [15:0]      x0_viol_cnt
);

   localparam int unsigned CW = (CNT_W > 32) ? CNT_W : 32;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] DR_LAST =
      (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

   mon_state_e state_q, state_d;
   fail_code_e code_q, code_d;
   logic       pass_q, pass_d;
   logic       done_q, done_d;
   logic       dump_q, dump_d;
   logic [31:0] drain_q, drain_d;

   logic          active, pc_x, sig_wr, x0_wr, x0_fatal;
   logic          timeout, ev;
   logic [CW-1:0] cyc_ext;

   assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign sig_wr = rf_we && (rf_a3 == 5'(SIG_REG));
   assign x0_wr  = rf_we && (rf_a3 == 5'd0) && (rf_wd3 != '0);

`ifdef SYNTHESIS
   assign pc_x = 1'b0;
`else
   assign pc_x = $isunknown(pc_f);
`endif

`ifdef SIM_MONITOR_X0_STRICT_EN
   assign x0_fatal = x0_wr;
`else
   assign x0_fatal = 1'b0;
`endif

   // Counter is zero-extended so a narrow CNT_W never aliases the limit.
   assign cyc_ext = CW'(cycle_cnt);
   assign timeout = (cyc_ext == TO_LAST);

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      pass_d  = pass_q;
      drain_d = drain_q;
      ev      = 1'b1;
      unique case (state_q)
         ST_IDLE: state_d = ST_RUN;
         ST_RUN: begin
            priority case (1'b1)
               pc_x: begin
                  code_d = FAIL_PC_X;
                  pass_d = 1'b0;
               end
               x0_fatal: begin
                  code_d = FAIL_X0_WRITE;
                  pass_d = 1'b0;
               end
               sig_wr && (rf_wd3 == FAIL_SIG): begin
                  code_d = FAIL_SIG_FAIL;
                  pass_d = 1'b0;
               end
               sig_wr && (rf_wd3 == PASS_SIG): begin
                  code_d = FAIL_NONE;
                  pass_d = 1'b1;
               end
               default: ev = 1'b0;
            endcase
            if (ev) begin
               state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
               drain_d = '0;
            end else if (timeout) begin
               state_d = ST_DONE;
               code_d  = FAIL_TIMEOUT;
               pass_d  = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DR_LAST)
               state_d = ST_DONE;
            else
               drain_d = drain_q + 32'd1;
         end
         ST_DONE: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
      if (rst) begin
         state_d = ST_IDLE;
         code_d  = FAIL_NONE;
         pass_d  = 1'b0;
         drain_d = '0;
      end
      done_d = (state_d == ST_DONE);
      dump_d = done_d && (state_q != ST_DONE);
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      code_q  <= code_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      dump_q  <= dump_d;
      drain_q <= drain_d;
   end

   sat_counter #(.W(CNT_W)) u_cyc (
      .clk (clk),
      .clr (rst),
      .inc (active),
      .q   (cycle_cnt)
   );

   sat_counter #(.W(CNT_W)) u_ret (
      .clk (clk),
      .clr (rst),
      .inc (active && retire),
      .q   (retire_cnt)
   );

   sat_counter #(.W(16)) u_x0 (
      .clk (clk),
      .clr (rst),
      .inc (active && x0_wr),
      .q   (x0_viol_cnt)
   );

   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_code = code_q;
   assign dump_req  = dump_q;

endmodule

// File: doc/sim_monitor.md
SIM_MONITOR -- requirements
Module: sim_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath/register width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning RUN cycles before timeout verdict.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 10, meaning cycles between verdict and DONE.
REQ-004 SHALL have parameter SIG_REG, default 31, meaning signature register index.
REQ-005 SHALL have parameter PASS_SIG, default 'h7FF, meaning pass checksum.
REQ-006 SHALL have parameter FAIL_SIG, default 'hBAD, meaning software-reported failure.
REQ-007 SHALL have parameter CNT_W, default 32, meaning counter width.
REQ-008 SHALL have port clk, input, 1, meaning single clock, rising edge.
REQ-009 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-010 SHALL have port pc_f, input, XLEN, meaning fetch PC.
REQ-011 SHALL have port rf_we, input, 1, meaning register-file write enable.
REQ-012 SHALL have port rf_a3, input, 5, meaning write address.
REQ-013 SHALL have port rf_wd3, input, XLEN, meaning write data.
REQ-014 SHALL have port retire, input, 1, meaning one instruction retired this cycle.
REQ-015 SHALL have port done, output, 1, meaning monitor in DONE.
REQ-016 SHALL have port pass, output, 1, meaning verdict pass, valid when done.
REQ-017 SHALL have port fail_code, output, 3, meaning 0 NONE, 1 PC_X, 2 SIG_FAIL, 3 TIMEOUT, 4 X0_WRITE.
REQ-018 SHALL have port dump_req, output, 1, meaning one-cycle pulse on entry to DONE.
REQ-019 SHALL have ports cycle_cnt/retire_cnt, output, CNT_W, meaning RUN cycles and retired instructions.
REQ-020 SHALL have port x0_viol_cnt, output, 16, meaning count of nonzero writes to x0.

Function
REQ-021 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on first clock edge with rst low.
REQ-022 In RUN, an event SHALL latch a verdict and move to DRAIN: pc_f has X/Z bits (simulation only, else never) gives PC_X; write to SIG_REG of FAIL_SIG gives SIG_FAIL; write to SIG_REG of PASS_SIG gives pass=1, code NONE.
REQ-023 Simultaneous events SHALL resolve by priority PC_X > X0_WRITE > SIG_FAIL > PASS > TIMEOUT.
REQ-024 When cycle_cnt reaches TIMEOUT_CYCLES-1 in RUN with no other event, the monitor SHALL go directly to DONE with TIMEOUT and skip DRAIN.
REQ-025 DRAIN SHALL last exactly DRAIN_CYCLES cycles, and DRAIN_CYCLES=0 SHALL enter DONE next cycle.
REQ-026 DONE SHALL be sticky until rst, verdict SHALL freeze, and later events SHALL be ignored.
REQ-027 dump_req SHALL be high exactly one cycle, the first cycle done=1.
REQ-028 cycle_cnt SHALL increment every RUN/DRAIN cycle, and retire_cnt SHALL increment on retire in RUN/DRAIN; both SHALL saturate at all-ones.
REQ-029 rf_we with rf_a3=0 and rf_wd3!=0 SHALL increment x0_viol_cnt (saturating) in RUN/DRAIN; zero-data writes (bubbles) SHALL NOT.
REQ-030 Outputs SHALL be registered with one-cycle latency from the triggering input.

Reset
REQ-031 rst SHALL force IDLE, done=0, pass=0, fail_code=0, dump_req=0, and all counters 0, including mid-RUN/DRAIN/DONE.

Configuration
REQ-032 With SIM_MONITOR_X0_STRICT_EN defined, a nonzero x0 write in RUN SHALL be fatal (X0_WRITE, to DRAIN); without it, such writes SHALL only be counted.

Structure
REQ-033 Package sim_monitor_pkg SHALL hold mon_state_e, fail_code_e and FAIL_* constants.
REQ-034 Counters SHALL use a sub-module sat_counter (parameter W, inc, clr, saturating).

Verification
REQ-035 The bench SHALL cover: write x31=0x7FF at RUN cycle 50 -> DRAIN, done and dump_req at cycle 61, pass=1, fail_code=0.
REQ-036 The bench SHALL cover: TIMEOUT_CYCLES=100 with no signature -> done at RUN cycle 100, pass=0, fail_code=3, no DRAIN.
REQ-037 The bench SHALL cover: x31=0x7FF and pc_f=X in the same cycle -> fail_code=1, pass=0.
REQ-038 The bench SHALL cover: three x0 writes of 5, 0, 7 -> x0_viol_cnt=2; strict build gives fail_code=4 after the first.
REQ-039 The bench SHALL cover: rst asserted in DRAIN cycle 3 -> IDLE next cycle with all outputs 0, then a clean rerun to pass.
REQ-040 The bench SHALL cover: CNT_W=4 with 20 retires -> retire_cnt=15 saturated.
